// File: rtl/arb_req_fifo.sv
// ---------------------------------------------------------------------------
// arb_req_fifo
//   Two independent per-channel request FIFOs feeding a 2-way round-robin
//   arbiter. Each non-empty queue raises its req bit. A one-hot grant pops
//   the head of that channel onto a registered output with one cycle of
//   latency.
//
// Parameters
//   DATA_W    payload width in bits
//   DEPTH     entries per channel queue (power of two, >= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   [1:0] per-channel write strobe
//   in_data0   channel 0 write payload
//   in_data1   channel 1 write payload
//   in_ready   [1:0] channel queue not full (from registered state)
//   req        [1:0] channel queue non-empty (from registered state)
//   grant      [1:0] arbiter grant (00, 01 or 10 are legal)
//   out_valid  one-cycle strobe marking a dequeued entry
//   out_data   dequeued payload (holds its value when no pop occurs)
//   out_ch     channel index of the dequeued payload
//   err        sticky protocol-error flag, present only when
//              ARB_REQ_FIFO_ERR_EN is defined
// ---------------------------------------------------------------------------
module arb_req_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        in_valid,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   output logic [1:0]        in_ready,
   output logic [1:0]        req,
   input  logic [1:0]        grant,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ch
`ifdef ARB_REQ_FIFO_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem    [2][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [2];
   logic [PTR_W-1:0]  rd_ptr [2];
   logic [CNT_W-1:0]  count  [2];
   logic [DATA_W-1:0] wdata  [2];
   logic [1:0]        push;
   logic [1:0]        pop;

   assign wdata[0] = in_data0;
   assign wdata[1] = in_data1;

   // Status flags come from the registered counts only.
   always_comb begin
      in_ready = 2'b00;
      req      = 2'b00;
      for (int i = 0; i < 2; i++) begin
         in_ready[i] = (count[i] != CNT_W'(DEPTH));
         req[i]      = (count[i] != '0);
      end
   end

   // Push needs room; pop needs a strictly one-hot grant and a non-empty queue.
   always_comb begin
      push    = in_valid & in_ready;
      pop     = 2'b00;
      pop[0]  = (grant == 2'b01) && req[0];
      pop[1]  = (grant == 2'b10) && req[1];
   end

   // Queue storage carries no reset; only pointers/counts define validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= wdata[i];
         end
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CNT_W'(1);
               2'b01:   count[i] <= count[i] - CNT_W'(1);
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // Registered dequeue port; data/channel hold between pops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= 1'b0;
      end else begin
         out_valid <= |pop;
         if (pop[0]) begin
            out_data <= mem[0][rd_ptr[0]];
            out_ch   <= 1'b0;
         end else if (pop[1]) begin
            out_data <= mem[1][rd_ptr[1]];
            out_ch   <= 1'b1;
         end
      end
   end

`ifdef ARB_REQ_FIFO_ERR_EN
   logic bad_c;

   // Illegal grant, grant to an empty queue, or a write into a full queue.
   always_comb begin
      bad_c = (grant == 2'b11)
            || ((grant == 2'b01) && !req[0])
            || ((grant == 2'b10) && !req[1])
            || (|(in_valid & ~in_ready));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (bad_c) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/arb_req_fifo.md
ARB_REQ_FIFO -- requirements
Module: arb_req_fifo

Interface
REQ-001 Parameter DATA_W, default 8, payload width per request in bits.
REQ-002 Parameter DEPTH, default 4, entries per channel queue; SHALL be a power of two >= 2.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port in_valid  input  2  per-channel write strobe, bit i = channel i.
REQ-006 Port in_data0  input  DATA_W  channel 0 write payload.
REQ-007 Port in_data1  input  DATA_W  channel 1 write payload.
REQ-008 Port in_ready  output  2  bit i high = channel i queue not full.
REQ-009 Port req  output  2  request vector to the 2-way round-robin arbiter; bit i high = channel i queue non-empty.
REQ-010 Port grant  input  2  grant vector from the arbiter; legal values 2'b00, 2'b01, 2'b10.
REQ-011 Port out_valid  output  1  one-cycle strobe: out_data/out_ch hold a dequeued entry.
REQ-012 Port out_data  output  DATA_W  dequeued payload.
REQ-013 Port out_ch  output  1  channel index of dequeued payload.

Function
REQ-014 Each channel SHALL hold an independent FIFO of DEPTH entries with read/write pointers of log2(DEPTH) bits and an occupancy count of log2(DEPTH)+1 bits.
REQ-015 A push on channel i SHALL occur on a rising edge when in_valid[i] and in_ready[i] are both high; in_valid[i] while in_ready[i] is low SHALL be ignored (data dropped, no state change).
REQ-016 in_ready[i] SHALL equal (count_i != DEPTH) and req[i] SHALL equal (count_i != 0), both decoded from registered state only (no combinational path from in_valid or grant).
REQ-017 A pop on channel i SHALL occur on a rising edge when grant is one-hot with bit i set and count_i != 0; a grant to an empty channel SHALL be ignored.
REQ-018 grant == 2'b11 SHALL cause no pop on either channel.
REQ-019 Pop latency SHALL be one cycle: the edge sampling a valid grant registers out_valid=1, out_data=head entry of channel i, out_ch=i; with no pop on an edge, out_valid SHALL be 0 after that edge and out_data/out_ch SHALL hold their last values.
REQ-020 A grant held high for N consecutive edges SHALL pop up to N entries, one per edge, until the channel empties.
REQ-021 Simultaneous push and pop on the same channel SHALL leave count unchanged and advance both pointers; on an empty channel a same-edge push and grant SHALL push only (pop ignored per REQ-017).
REQ-022 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap-around.
REQ-023 Channels SHALL be fully independent: activity on one SHALL not alter the other's count, pointers or contents.

Reset
REQ-024 While rst is high, SHALL asynchronously clear all counts and pointers, out_valid=0, out_data=0, out_ch=0, giving req=2'b00 and in_ready=2'b11.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries; the first edge after deassertion SHALL behave as from empty.

Configuration
REQ-026 With macro ARB_REQ_FIFO_ERR_EN defined, SHALL add output err (1 bit), a sticky flag set on an edge with grant==2'b11, a grant to an empty channel, or in_valid[i] while in_ready[i] is low; cleared only by rst.
REQ-027 Without ARB_REQ_FIFO_ERR_EN, port err and its logic SHALL be absent; all other behaviour identical.

Verification (DATA_W=8, DEPTH=4)
REQ-028 Reset: rst=1 mid-traffic with 3 entries queued -> req=2'b00, in_ready=2'b11, out_valid=0 immediately; after release, grant=2'b01 -> no out_valid.
REQ-029 Ordering: push 8'hA1,8'hA2 on ch0, then grant=2'b01 for 2 edges -> out_valid high 2 cycles, out_data 8'hA1 then 8'hA2, out_ch=0, then req[0]=0.
REQ-030 Full: push 5 values on ch1 -> in_ready[1]=0 after 4th push, 5th dropped (err=1 if ERR_EN); draining 4 pops returns the first 4 in order.
REQ-031 Wrap: repeat push-1/pop-1 on ch0 for 10 cycles with payloads 0..9 -> out_data 0..9 in order, count never exceeds 1.
REQ-032 Alternation: both channels loaded with 2 entries, grant toggles 2'b01/2'b10 -> out_ch alternates 0,1,0,1 with correct per-channel order; grant=2'b11 injected -> no pop, err=1 if ERR_EN.
REQ-033 Simultaneous: ch0 full, same-edge push 8'h55 and grant=2'b01 -> push rejected (in_ready[0]=0), one pop, count 3; ch0 at count 2, same-edge push and pop -> count stays 2.
